// File: rtl/noise_pkg.sv
// Shared constants, FSM state type and LCG step for the gaussian/uniform noise source.
package noise_pkg;

    localparam int DEF_OUT_W          = 12;
    localparam int DEF_Z_W            = 36;
    localparam int DEF_U_W            = 16;
    localparam int DEF_N_SUM          = 12;
    localparam int DEF_SAMPLES_PER_US = 13000;
    localparam int DEF_T_W            = 10;
    localparam int DEF_CNT_W          = 32;

    localparam logic [DEF_Z_W-1:0] DEF_LCG_L = DEF_Z_W'(31);
    localparam logic [DEF_Z_W-1:0] DEF_LCG_U = DEF_Z_W'(1);

    localparam logic [1:0] SIG_SINE   = 2'd0;
    localparam logic [1:0] SIG_SQUARE = 2'd1;
    localparam logic [1:0] SIG_CHIRP  = 2'd2;
    localparam logic [1:0] SIG_NOISE  = 2'd3;
    localparam logic [1:0] NOISE_TYPE = SIG_NOISE;

    localparam logic MODE_GAUSS   = 1'b0;
    localparam logic MODE_UNIFORM = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    function automatic logic [DEF_Z_W-1:0] lcg_next(input logic [DEF_Z_W-1:0] z);
        return z * DEF_LCG_L + DEF_LCG_U;
    endfunction

endpackage

// File: rtl/noise_lcg_stage.sv
// One pipeline stage: advance the LCG once and add the uniform taken from its MSBs.
module noise_lcg_stage
    import noise_pkg::*;
#(
    parameter int               Z_W   = DEF_Z_W,
    parameter int               U_W   = DEF_U_W,
    parameter int               ACC_W = DEF_U_W + 4,
    parameter int               TAG_W = 2,
    parameter logic [Z_W-1:0]   LCG_L = Z_W'(31),
    parameter logic [Z_W-1:0]   LCG_U = Z_W'(1)
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             flush,
    input  logic             valid_in,
    input  logic [Z_W-1:0]   z_in,
    input  logic [ACC_W-1:0] acc_in,
    input  logic [TAG_W-1:0] tag_in,
    output logic             valid_out,
    output logic [Z_W-1:0]   z_out,
    output logic [ACC_W-1:0] acc_out,
    output logic [TAG_W-1:0] tag_out
);

    logic [Z_W-1:0] z_next;

    assign z_next = z_in * LCG_L + LCG_U;

    always_ff @(posedge CLK) begin
        if (RESET || flush) begin
            valid_out <= 1'b0;
        end else begin
            valid_out <= valid_in;
        end
    end

    // Data path is never reset; only the valid bit qualifies it.
    always_ff @(posedge CLK) begin
        z_out   <= z_next;
        acc_out <= acc_in + ACC_W'(z_next[Z_W-1 -: U_W]);
        tag_out <= tag_in;
    end

endmodule

// File: rtl/gauss_noise_gen.sv
// Pipelined CLT noise source: N_SUM LCG stages, scale stage, saturating output register.
module gauss_noise_gen
    import noise_pkg::*;
#(
    parameter int             OUT_W          = DEF_OUT_W,
    parameter int             Z_W            = DEF_Z_W,
    parameter int             U_W            = DEF_U_W,
    parameter int             N_SUM          = DEF_N_SUM,
    parameter logic [Z_W-1:0] LCG_L          = Z_W'(31),
    parameter logic [Z_W-1:0] LCG_U          = Z_W'(1),
    parameter int             SAMPLES_PER_US = DEF_SAMPLES_PER_US,
    parameter int             T_W            = DEF_T_W,
    parameter int             CNT_W          = DEF_CNT_W,
    parameter logic [1:0]     NOISE_SEL      = NOISE_TYPE
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [1:0]       SIGNAL_TYPE,
    input  logic [T_W-1:0]   T_IMPULSE,
    input  logic             MODE,
    input  logic [Z_W-1:0]   SEED,
    input  logic [OUT_W-1:0] SIGMA,
    input  logic [OUT_W-1:0] MEAN,
    input  logic             SIGN_START_GEN,
    input  logic             SIGN_ABORT,
    input  logic             OUT_REG_READY,
    output logic             SIGN_START_CALC,
    output logic             SIGN_STOP_CALC,
    output logic             NOISE_VALID,
    output logic [OUT_W-1:0] NOISE_OUT,
    output logic             BUSY
);

    localparam int ACC_W = U_W + $clog2(N_SUM + 1);
    localparam int C_W   = ACC_W + 1;
    localparam int P_W   = C_W + OUT_W + 1;
    localparam int Y_W   = P_W + 1;
    localparam int LAT   = N_SUM + 2;

    // Token t starts from the LCG state N_SUM*t steps past SEED, so the base
    // register jumps N_SUM steps per issued token: z' = A*z + C.
    function automatic logic [Z_W-1:0] jump_mul(input int n);
        logic [Z_W-1:0] a;
        a = Z_W'(1);
        for (int i = 0; i < n; i++) a = a * LCG_L;
        return a;
    endfunction

    function automatic logic [Z_W-1:0] jump_add(input int n);
        logic [Z_W-1:0] c;
        c = '0;
        for (int i = 0; i < n; i++) c = c * LCG_L + LCG_U;
        return c;
    endfunction

    localparam logic [Z_W-1:0] JUMP_A   = jump_mul(N_SUM);
    localparam logic [Z_W-1:0] JUMP_C   = jump_add(N_SUM);
    localparam logic [C_W-1:0] ACC_BIAS = C_W'(N_SUM) << (U_W - 1);

    state_t             state, state_next;
    logic [CNT_W-1:0]   cnt, num;
    logic               mode_r;
    logic [OUT_W-1:0]   mean_r, sigma_r;
    logic [Z_W-1:0]     z_base;
    logic               accept, abort, issue;

    logic               v_s   [0:N_SUM];
    logic [Z_W-1:0]     z_s   [0:N_SUM];
    logic [ACC_W-1:0]   acc_s [0:N_SUM];
    logic [1:0]         tag_s [0:N_SUM];

    logic               sc_valid;
    logic [1:0]         sc_tag;
    logic signed [Y_W-1:0] sc_y;
    logic [OUT_W-1:0]   sc_u;

    assign accept = (state == IDLE) && SIGN_START_GEN && OUT_REG_READY &&
                    (SIGNAL_TYPE == NOISE_SEL) && (T_IMPULSE != '0);
    assign abort  = SIGN_ABORT && (state != IDLE);
    assign BUSY   = (state != IDLE);

    always_ff @(posedge CLK) begin
        if (RESET) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        issue      = 1'b0;
        case (state)
            IDLE:  if (accept) state_next = RUN;
            RUN: begin
                issue = 1'b1;
                if (cnt == num - CNT_W'(1)) state_next = FLUSH;
            end
            FLUSH: if (cnt == CNT_W'(LAT - 1)) state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (abort) begin
            state_next = IDLE;
            issue      = 1'b0;
        end
    end

    // cnt indexes tokens in RUN and drain cycles in FLUSH; it restarts on every state change.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            cnt     <= '0;
            num     <= '0;
            mode_r  <= MODE_GAUSS;
            mean_r  <= '0;
            sigma_r <= '0;
            z_base  <= '0;
        end else begin
            if (state_next != state) cnt <= '0;
            else if (state != IDLE)  cnt <= cnt + CNT_W'(1);
            if (accept) begin
                num     <= CNT_W'(T_IMPULSE) * CNT_W'(SAMPLES_PER_US);
                mode_r  <= MODE;
                mean_r  <= MEAN;
                sigma_r <= SIGMA;
                z_base  <= SEED;
            end else if (issue) begin
                z_base  <= z_base * JUMP_A + JUMP_C;
            end
        end
    end

    assign v_s[0]   = issue;
    assign z_s[0]   = z_base;
    assign acc_s[0] = '0;
    assign tag_s[0] = {cnt == '0, cnt == num - CNT_W'(1)};

    for (genvar g = 0; g < N_SUM; g++) begin : g_stage
        noise_lcg_stage #(
            .Z_W(Z_W), .U_W(U_W), .ACC_W(ACC_W), .TAG_W(2), .LCG_L(LCG_L), .LCG_U(LCG_U)
        ) u_stage (
            .CLK(CLK), .RESET(RESET), .flush(abort),
            .valid_in(v_s[g]), .z_in(z_s[g]), .acc_in(acc_s[g]), .tag_in(tag_s[g]),
            .valid_out(v_s[g+1]), .z_out(z_s[g+1]), .acc_out(acc_s[g+1]), .tag_out(tag_s[g+1])
        );
    end

    // Centre the sum, scale by SIGMA in units of 2^-U_W, then offset by MEAN.
    logic signed [C_W-1:0] c_val;
    logic signed [P_W-1:0] prod, scaled;
    logic signed [Y_W-1:0] y_val;

    assign c_val  = $signed({1'b0, acc_s[N_SUM]}) - $signed(ACC_BIAS);
    assign prod   = P_W'(c_val) * P_W'($signed({1'b0, sigma_r}));
    assign scaled = prod >>> U_W;
    assign y_val  = Y_W'(scaled) + Y_W'($signed({1'b0, mean_r}));

    always_ff @(posedge CLK) begin
        if (RESET || abort) sc_valid <= 1'b0;
        else                sc_valid <= v_s[N_SUM];
        sc_tag <= tag_s[N_SUM];
        sc_y   <= y_val;
        sc_u   <= z_s[N_SUM][Z_W-1 -: OUT_W];
    end

    logic [OUT_W-1:0] sat_y;

    always_comb begin
        sat_y = sc_y[OUT_W-1:0];
        if (sc_y[Y_W-1])                sat_y = '0;
        else if (|sc_y[Y_W-2:OUT_W])    sat_y = '1;
    end

    always_ff @(posedge CLK) begin
        if (RESET || abort) begin
            NOISE_VALID     <= 1'b0;
            NOISE_OUT       <= '0;
            SIGN_START_CALC <= 1'b0;
            SIGN_STOP_CALC  <= 1'b0;
        end else begin
            NOISE_VALID     <= sc_valid;
            SIGN_START_CALC <= sc_valid && sc_tag[1];
            SIGN_STOP_CALC  <= sc_valid && sc_tag[0];
            if (!sc_valid)                    NOISE_OUT <= '0;
            else if (mode_r == MODE_UNIFORM)  NOISE_OUT <= sc_u;
            else                              NOISE_OUT <= sat_y;
        end
    end

endmodule

// File: tb/tb_gauss_noise_gen.sv
// Bench for gauss_noise_gen: per-scenario tasks checked against an LCG/CLT reference model.
module tb_gauss_noise_gen;
    import noise_pkg::*;

    localparam int N   = DEF_N_SUM;
    localparam int LAT = N + 2;
    localparam int SPU = DEF_SAMPLES_PER_US;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [1:0]  SIGNAL_TYPE;
    logic [9:0]  T_IMPULSE;
    logic        MODE;
    logic [35:0] SEED;
    logic [11:0] SIGMA, MEAN;
    logic        SIGN_START_GEN, SIGN_ABORT, OUT_REG_READY;
    logic        SIGN_START_CALC, SIGN_STOP_CALC, NOISE_VALID, BUSY;
    logic [11:0] NOISE_OUT;

    int total = 0;
    int bad   = 0;
    logic [11:0] exp_q[$];

    gauss_noise_gen dut (
        .CLK(CLK), .RESET(RESET), .SIGNAL_TYPE(SIGNAL_TYPE), .T_IMPULSE(T_IMPULSE),
        .MODE(MODE), .SEED(SEED), .SIGMA(SIGMA), .MEAN(MEAN),
        .SIGN_START_GEN(SIGN_START_GEN), .SIGN_ABORT(SIGN_ABORT), .OUT_REG_READY(OUT_REG_READY),
        .SIGN_START_CALC(SIGN_START_CALC), .SIGN_STOP_CALC(SIGN_STOP_CALC),
        .NOISE_VALID(NOISE_VALID), .NOISE_OUT(NOISE_OUT), .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached, required all tests complete");
        $fatal(1, "watchdog expired");
    end

    // Reference model: every sample consumes N fresh LCG outputs from one continuous stream.
    task automatic model_fill(input logic [35:0] seed, input logic md, input int mu,
                              input int sg, input int n);
        logic [35:0] z;
        longint acc, c, t, q, y;
        exp_q.delete();
        z = seed;
        for (int i = 0; i < n; i++) begin
            acc = 0;
            for (int k = 0; k < N; k++) begin
                z = lcg_next(z);
                acc += longint'(z[35:20]);
            end
            if (md) begin
                exp_q.push_back(z[35:24]);
            end else begin
                c = acc - longint'(N) * 32768;
                t = c * sg;
                q = t / 65536;
                if (t < 0 && (t % 65536) != 0) q = q - 1;
                y = mu + q;
                if (y < 0) y = 0;
                else if (y > 4095) y = 4095;
                exp_q.push_back(12'(y));
            end
        end
    endtask

    task automatic issue_start(input logic [1:0] st, input logic [9:0] ti, input logic md,
                               input logic [35:0] sd, input logic [11:0] mu,
                               input logic [11:0] sg, input logic rdy);
        @(posedge CLK); #1;
        SIGNAL_TYPE = st; T_IMPULSE = ti; MODE = md; SEED = sd;
        MEAN = mu; SIGMA = sg; OUT_REG_READY = rdy; SIGN_START_GEN = 1'b1;
        @(posedge CLK); #1;
        SIGN_START_GEN = 1'b0;
    endtask

    // k = 1 is the negedge right after the accepting edge.
    task automatic wait_first_valid(output int k);
        k = 0;
        do begin
            @(negedge CLK);
            k++;
        end while (NOISE_VALID !== 1'b1 && k < 4 * LAT);
    endtask

    task automatic do_abort();
        SIGN_ABORT = 1'b1;
        @(negedge CLK);
        SIGN_ABORT = 1'b0;
    endtask

    function automatic logic [35:0] rand_seed();
        return {4'($urandom_range(15, 0)), 32'($urandom)};
    endfunction

    task automatic test_reset();
        RESET = 1'b1; SIGNAL_TYPE = 2'd0; T_IMPULSE = '0; MODE = 1'b0; SEED = '0;
        SIGMA = '0; MEAN = '0; SIGN_START_GEN = 1'b0; SIGN_ABORT = 1'b0; OUT_REG_READY = 1'b0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        total++;
        if ({NOISE_VALID, NOISE_OUT, SIGN_START_CALC, SIGN_STOP_CALC, BUSY} !== 16'h0) begin
            bad++;
            $display("FAIL reset: valid=%0b out=%0d start=%0b stop=%0b busy=%0b, required all 0",
                     NOISE_VALID, NOISE_OUT, SIGN_START_CALC, SIGN_STOP_CALC, BUSY);
        end
        RESET = 1'b0;
    endtask

    task automatic test_burst();
        int k, n;
        real s, ss, m, sd;
        n = SPU;
        s = 0.0; ss = 0.0;
        model_fill(36'd16383, MODE_GAUSS, 2047, 682, n);
        issue_start(NOISE_TYPE, 10'd1, MODE_GAUSS, 36'd16383, 12'd2047, 12'd682, 1'b1);
        wait_first_valid(k);
        total++;
        if (k != LAT + 1) begin
            bad++;
            $display("FAIL burst latency: first valid at cycle %0d, required %0d", k, LAT + 1);
        end
        if (NOISE_VALID !== 1'b1) return;
        for (int i = 0; i < n; i++) begin
            total++;
            if (NOISE_VALID !== 1'b1 || NOISE_OUT !== exp_q[i] || BUSY !== 1'b1 ||
                SIGN_START_CALC !== (i == 0) || SIGN_STOP_CALC !== (i == n - 1)) begin
                bad++;
                $display("FAIL burst sample %0d: valid=%0b out=%0d start=%0b stop=%0b busy=%0b, required 1 %0d %0b %0b 1",
                         i, NOISE_VALID, NOISE_OUT, SIGN_START_CALC, SIGN_STOP_CALC, BUSY,
                         exp_q[i], i == 0, i == n - 1);
            end
            s  += real'(NOISE_OUT);
            ss += real'(NOISE_OUT) * real'(NOISE_OUT);
            // Inputs changed mid-burst must not disturb the latched configuration.
            if (i == 10) begin
                SIGN_START_GEN = 1'b1; SEED = rand_seed(); MEAN = '0; SIGMA = 12'd4095; MODE = 1'b1;
            end
            if (i == 11) SIGN_START_GEN = 1'b0;
            if (i < n - 1) @(negedge CLK);
        end
        @(negedge CLK);
        total++;
        if (NOISE_VALID !== 1'b0 || NOISE_OUT !== 12'd0 || BUSY !== 1'b0 || SIGN_STOP_CALC !== 1'b0) begin
            bad++;
            $display("FAIL burst end: valid=%0b out=%0d busy=%0b stop=%0b, required 0 0 0 0",
                     NOISE_VALID, NOISE_OUT, BUSY, SIGN_STOP_CALC);
        end
        m  = s / n;
        sd = $sqrt(ss / n - m * m);
        total++;
        if (m < 2027.0 || m > 2067.0) begin
            bad++;
            $display("FAIL burst mean: got %f, required 2047 +-20", m);
        end
        // Multiplier 31 gives adjacent uniforms a correlation of 1/31, which lifts the
        // CLT spread about 3% above SIGMA; the window is widened upward accordingly.
        total++;
        if (sd < 662.0 || sd > 722.0) begin
            bad++;
            $display("FAIL burst std: got %f, required 662..722", sd);
        end
    endtask

    task automatic test_clamp();
        int k, zeros, tops;
        logic [35:0] sd;
        zeros = 0; tops = 0;
        sd = rand_seed();
        model_fill(sd, MODE_GAUSS, 0, 4095, 2000);
        issue_start(NOISE_TYPE, 10'd1, MODE_GAUSS, sd, 12'd0, 12'd4095, 1'b1);
        wait_first_valid(k);
        total++;
        if (k != LAT + 1) begin
            bad++;
            $display("FAIL clamp latency: first valid at cycle %0d, required %0d", k, LAT + 1);
        end
        if (NOISE_VALID !== 1'b1) return;
        for (int i = 0; i < 2000; i++) begin
            total++;
            if (NOISE_VALID !== 1'b1 || NOISE_OUT !== exp_q[i]) begin
                bad++;
                $display("FAIL clamp sample %0d: valid=%0b out=%0d, required 1 %0d",
                         i, NOISE_VALID, NOISE_OUT, exp_q[i]);
            end
            if (NOISE_OUT == 12'd0)    zeros++;
            if (NOISE_OUT == 12'd4095) tops++;
            if (i < 1999) @(negedge CLK);
        end
        do_abort();
        total++;
        if (zeros < 100 || tops < 100) begin
            bad++;
            $display("FAIL clamp counts: zeros=%0d tops=%0d, required both >= 100", zeros, tops);
        end
    endtask

    task automatic test_uniform();
        int k;
        logic [35:0] sd;
        sd = rand_seed();
        model_fill(sd, MODE_UNIFORM, 0, 0, 300);
        issue_start(NOISE_TYPE, 10'd2, MODE_UNIFORM, sd, 12'($urandom), 12'($urandom), 1'b1);
        wait_first_valid(k);
        if (NOISE_VALID !== 1'b1) begin
            total++; bad++;
            $display("FAIL uniform first valid: none within %0d cycles, required at %0d", k, LAT + 1);
            return;
        end
        for (int i = 0; i < 300; i++) begin
            total++;
            if (NOISE_VALID !== 1'b1 || NOISE_OUT !== exp_q[i] || SIGN_START_CALC !== (i == 0)) begin
                bad++;
                $display("FAIL uniform sample %0d: valid=%0b out=%0d start=%0b, required 1 %0d %0b",
                         i, NOISE_VALID, NOISE_OUT, SIGN_START_CALC, exp_q[i], i == 0);
            end
            if (i < 299) @(negedge CLK);
        end
        do_abort();
    endtask

    task automatic test_random_params();
        int k, mu, sg;
        logic [35:0] sd;
        for (int r = 0; r < 4; r++) begin
            sd = rand_seed();
            mu = $urandom_range(4095, 0);
            sg = $urandom_range(4095, 0);
            model_fill(sd, MODE_GAUSS, mu, sg, 200);
            issue_start(NOISE_TYPE, 10'($urandom_range(1023, 1)), MODE_GAUSS, sd, 12'(mu), 12'(sg), 1'b1);
            wait_first_valid(k);
            total++;
            if (k != LAT + 1) begin
                bad++;
                $display("FAIL random latency run %0d: first valid at cycle %0d, required %0d", r, k, LAT + 1);
            end
            if (NOISE_VALID !== 1'b1) return;
            for (int i = 0; i < 200; i++) begin
                total++;
                if (NOISE_VALID !== 1'b1 || NOISE_OUT !== exp_q[i]) begin
                    bad++;
                    $display("FAIL random run %0d sample %0d: valid=%0b out=%0d, required 1 %0d (mean %0d sigma %0d)",
                             r, i, NOISE_VALID, NOISE_OUT, exp_q[i], mu, sg);
                end
                if (i < 199) @(negedge CLK);
            end
            do_abort();
        end
    endtask

    task automatic test_rejects();
        logic [1:0] st [3];
        logic       rd [3];
        logic [9:0] ti [3];
        st = '{2'd2, NOISE_TYPE, NOISE_TYPE};
        rd = '{1'b1, 1'b0, 1'b1};
        ti = '{10'd1, 10'd1, 10'd0};
        for (int c = 0; c < 3; c++) begin
            issue_start(st[c], ti[c], MODE_GAUSS, 36'd5, 12'd2047, 12'd682, rd[c]);
            for (int j = 0; j < LAT + 4; j++) begin
                @(negedge CLK);
                total++;
                if (BUSY !== 1'b0 || NOISE_VALID !== 1'b0 || SIGN_START_CALC !== 1'b0) begin
                    bad++;
                    $display("FAIL reject case %0d cycle %0d: busy=%0b valid=%0b start=%0b, required 0 0 0",
                             c, j, BUSY, NOISE_VALID, SIGN_START_CALC);
                end
            end
        end
    endtask

    task automatic test_abort();
        int k;
        logic [35:0] sd;
        sd = rand_seed();
        model_fill(sd, MODE_GAUSS, 2047, 682, 501);
        issue_start(NOISE_TYPE, 10'd1, MODE_GAUSS, sd, 12'd2047, 12'd682, 1'b1);
        wait_first_valid(k);
        if (NOISE_VALID !== 1'b1) begin
            total++; bad++;
            $display("FAIL abort first valid: none within %0d cycles, required at %0d", k, LAT + 1);
            return;
        end
        for (int i = 0; i <= 500; i++) begin
            total++;
            if (NOISE_VALID !== 1'b1 || NOISE_OUT !== exp_q[i]) begin
                bad++;
                $display("FAIL abort pre sample %0d: valid=%0b out=%0d, required 1 %0d",
                         i, NOISE_VALID, NOISE_OUT, exp_q[i]);
            end
            if (i < 500) @(negedge CLK);
        end
        do_abort();
        total++;
        if (NOISE_VALID !== 1'b0 || NOISE_OUT !== 12'd0 || SIGN_STOP_CALC !== 1'b0 || BUSY !== 1'b0) begin
            bad++;
            $display("FAIL abort next cycle: valid=%0b out=%0d stop=%0b busy=%0b, required 0 0 0 0",
                     NOISE_VALID, NOISE_OUT, SIGN_STOP_CALC, BUSY);
        end
        for (int j = 0; j < LAT + 2; j++) begin
            @(negedge CLK);
            total++;
            if (NOISE_VALID !== 1'b0 || SIGN_STOP_CALC !== 1'b0) begin
                bad++;
                $display("FAIL abort drain cycle %0d: valid=%0b stop=%0b, required 0 0",
                         j, NOISE_VALID, SIGN_STOP_CALC);
            end
        end
        model_fill(36'd16383, MODE_GAUSS, 2047, 682, 32);
        issue_start(NOISE_TYPE, 10'd1, MODE_GAUSS, 36'd16383, 12'd2047, 12'd682, 1'b1);
        wait_first_valid(k);
        total++;
        if (k != LAT + 1) begin
            bad++;
            $display("FAIL abort restart latency: first valid at cycle %0d, required %0d", k, LAT + 1);
        end
        if (NOISE_VALID !== 1'b1) return;
        for (int i = 0; i < 32; i++) begin
            total++;
            if (NOISE_VALID !== 1'b1 || NOISE_OUT !== exp_q[i]) begin
                bad++;
                $display("FAIL abort restart sample %0d: valid=%0b out=%0d, required 1 %0d",
                         i, NOISE_VALID, NOISE_OUT, exp_q[i]);
            end
            if (i < 31) @(negedge CLK);
        end
        do_abort();
    endtask

    task automatic test_reset_mid();
        int k;
        model_fill(36'd16383, MODE_GAUSS, 2047, 682, 101);
        issue_start(NOISE_TYPE, 10'd3, MODE_GAUSS, 36'd16383, 12'd2047, 12'd682, 1'b1);
        wait_first_valid(k);
        if (NOISE_VALID !== 1'b1) begin
            total++; bad++;
            $display("FAIL reset-mid first valid: none within %0d cycles, required at %0d", k, LAT + 1);
            return;
        end
        repeat (100) @(negedge CLK);
        total++;
        if (NOISE_VALID !== 1'b1 || NOISE_OUT !== exp_q[100]) begin
            bad++;
            $display("FAIL reset-mid sample 100: valid=%0b out=%0d, required 1 %0d",
                     NOISE_VALID, NOISE_OUT, exp_q[100]);
        end
        RESET = 1'b1;
        @(negedge CLK);
        RESET = 1'b0;
        total++;
        if ({NOISE_VALID, NOISE_OUT, SIGN_START_CALC, SIGN_STOP_CALC, BUSY} !== 16'h0) begin
            bad++;
            $display("FAIL reset-mid outputs: valid=%0b out=%0d start=%0b stop=%0b busy=%0b, required all 0",
                     NOISE_VALID, NOISE_OUT, SIGN_START_CALC, SIGN_STOP_CALC, BUSY);
        end
        model_fill(36'd16383, MODE_GAUSS, 2047, 682, 64);
        issue_start(NOISE_TYPE, 10'd1, MODE_GAUSS, 36'd16383, 12'd2047, 12'd682, 1'b1);
        wait_first_valid(k);
        total++;
        if (k != LAT + 1) begin
            bad++;
            $display("FAIL reset-mid restart latency: first valid at cycle %0d, required %0d", k, LAT + 1);
        end
        if (NOISE_VALID !== 1'b1) return;
        for (int i = 0; i < 64; i++) begin
            total++;
            if (NOISE_VALID !== 1'b1 || NOISE_OUT !== exp_q[i] || SIGN_START_CALC !== (i == 0)) begin
                bad++;
                $display("FAIL reset-mid restart sample %0d: valid=%0b out=%0d start=%0b, required 1 %0d %0b",
                         i, NOISE_VALID, NOISE_OUT, SIGN_START_CALC, exp_q[i], i == 0);
            end
            if (i < 63) @(negedge CLK);
        end
        do_abort();
    endtask

    initial begin
        test_reset();
        test_burst();
        test_rejects();
        test_clamp();
        test_uniform();
        test_random_params();
        test_abort();
        test_reset_mid();
        repeat (2) @(negedge CLK);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
